// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_COLS   = 4;
  localparam int NUM_ROWS   = 4;
  localparam int NUM_KEYS   = 16;
  localparam int KEY_CODE_W = 4;
  localparam int EVENT_W    = KEY_CODE_W + 1;

  typedef enum logic [1:0] {
    ST_DRIVE  = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_EVAL   = 2'd2,
    ST_GAP    = 2'd3
  } scan_state_t;

  function automatic logic [NUM_COLS-1:0] col_onehot(input logic [1:0] col);
    return 4'b0001 << col;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Four-entry event queue; entries are {release, code}.
module key_event_fifo
  import keypad_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [EVENT_W-1:0] i_data,
  input  logic               i_pop,
  output logic [EVENT_W-1:0] o_data,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_drop
);

  logic [EVENT_W-1:0] r_mem [0:3];
  logic [1:0]         r_wr_ptr;
  logic [1:0]         r_rd_ptr;
  logic [2:0]         r_count;
  logic               w_pop_ok;
  logic               w_push_ok;

  assign o_full    = (r_count == 3'd4);
  assign o_empty   = (r_count == 3'd0);
  // A pop against an empty queue is ignored; a pop frees room for a push when full.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_drop    = i_push && !w_push_ok;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/keypad_scan_controller.sv
// Column-scanning 4x4 keypad controller with per-key debounce and a press/release event queue.
module keypad_scan_controller
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  IOIn,
  output logic [3:0]  IOOut,
  output logic        KEY_VALID,
  input  logic        KEY_READY,
  output logic [3:0]  KEY_CODE,
  output logic        KEY_RELEASE,
  output logic [15:0] KEYS_DOWN,
  output logic        OVERFLOW,
  output logic [1:0]  DBG_STATE
);

  // Handshake: an event transfers on a rising edge where KEY_VALID && KEY_READY;
  // the head (KEY_CODE/KEY_RELEASE) holds until that transfer.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] DEB_TARGET  = 3'(DEBOUNCE_SCANS);

  scan_state_t        r_state;
  scan_state_t        w_next_state;
  logic [3:0]         r_settle;
  logic [1:0]         r_col;
  logic [3:0]         r_key;
  logic [15:0]        r_raw;
  logic [15:0]        r_stable;
  logic [2:0]         r_cnt [0:NUM_KEYS-1];
  logic               r_overflow;
  logic [3:0]         w_iout;
  logic               w_differ;
  logic [2:0]         w_cnt_inc;
  logic               w_flip;
  logic [EVENT_W-1:0] w_event;
  logic [EVENT_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_DRIVE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_iout       = '0;
    case (r_state)
      ST_DRIVE: begin
        w_iout = col_onehot(r_col);
        if (r_settle == SETTLE_LAST) w_next_state = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        w_iout       = col_onehot(r_col);
        w_next_state = (r_col == 2'd3) ? ST_EVAL : ST_DRIVE;
      end
      ST_EVAL: begin
        if (r_key == 4'd15) w_next_state = ST_GAP;
      end
      ST_GAP: begin
        w_next_state = ST_DRIVE;
      end
      default: w_next_state = ST_DRIVE;
    endcase
  end

  // Debounce of the key currently under evaluation; the event carries the
  // old stable level as its release flag (old=1 means the key just opened).
  assign w_differ  = r_raw[r_key] != r_stable[r_key];
  assign w_cnt_inc = r_cnt[r_key] + 3'd1;
  assign w_flip    = (r_state == ST_EVAL) && w_differ && (w_cnt_inc == DEB_TARGET);
  assign w_event   = {r_stable[r_key], r_key};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_settle <= '0;
      r_col    <= '0;
      r_key    <= '0;
      r_raw    <= '0;
      r_stable <= '0;
      for (int i = 0; i < NUM_KEYS; i++) r_cnt[i] <= '0;
    end else begin
      case (r_state)
        ST_DRIVE: begin
          r_settle <= (r_settle == SETTLE_LAST) ? 4'd0 : r_settle + 4'd1;
        end
        ST_SAMPLE: begin
          r_raw[{r_col, 2'b00} +: NUM_ROWS] <= IOIn;
          r_col <= r_col + 2'd1;
          r_key <= '0;
        end
        ST_EVAL: begin
          r_key <= r_key + 4'd1;
          if (!w_differ) begin
            r_cnt[r_key] <= '0;
          end else if (w_flip) begin
            r_cnt[r_key]    <= '0;
            r_stable[r_key] <= ~r_stable[r_key];
          end else begin
            r_cnt[r_key] <= w_cnt_inc;
          end
        end
        ST_GAP: begin
          r_col    <= '0;
          r_settle <= '0;
        end
        default: ;
      endcase
    end
  end

  key_event_fifo u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_flip),
    .i_data  (w_event),
    .i_pop   (KEY_READY),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_overflow <= 1'b0;
    else     r_overflow <= r_overflow | w_drop;
  end

  // State resets to DRIVE/col 0, so the column drive is masked while reset is held.
  assign IOOut       = RST ? 4'b0000 : w_iout;
  assign KEY_VALID   = !w_empty;
  assign KEY_CODE    = w_head[KEY_CODE_W-1:0];
  assign KEY_RELEASE = w_head[KEY_CODE_W];
  assign KEYS_DOWN   = r_stable;
  assign OVERFLOW    = r_overflow;
  assign DBG_STATE   = r_state;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Randomized and directed bench for keypad_scan_controller with a scan-level reference model.
module tb_keypad_scan_controller;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int PERIOD = 4 * (SETTLE + 1) + 17;
  localparam int EW     = 14;  // {check_scan, scan[7:0], release, code[3:0]}

  logic        CLK;
  logic        RST;
  logic [3:0]  IOIn;
  logic [3:0]  IOOut;
  logic        KEY_VALID;
  logic        KEY_READY;
  logic [3:0]  KEY_CODE;
  logic        KEY_RELEASE;
  logic [15:0] KEYS_DOWN;
  logic        OVERFLOW;
  logic [1:0]  DBG_STATE;

  keypad_scan_controller #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IOIn        (IOIn),
    .IOOut       (IOOut),
    .KEY_VALID   (KEY_VALID),
    .KEY_READY   (KEY_READY),
    .KEY_CODE    (KEY_CODE),
    .KEY_RELEASE (KEY_RELEASE),
    .KEYS_DOWN   (KEYS_DOWN),
    .OVERFLOW    (OVERFLOW),
    .DBG_STATE   (DBG_STATE)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Key matrix: a closed key connects its column line to its row line.
  logic [15:0] keys_closed;
  always_comb begin
    IOIn = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (IOOut[c] && keys_closed[c*4+r]) IOIn[r] = 1'b1;
  end

  // Scoreboard state and reference model
  logic [EW-1:0] exp_q[$];
  int            n_chk;
  int            n_err;
  logic [7:0]    cur_scan;
  logic [15:0]   m_stable;
  int            m_cnt [16];
  logic          m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (scan %0d)", name, act, exp, cur_scan);
    end
  endtask

  task automatic model_reset();
    m_stable = '0;
    m_ovf    = 1'b0;
    for (int k = 0; k < 16; k++) m_cnt[k] = 0;
    exp_q.delete();
  endtask

  // One scan with the keys held at pat for the whole scan.
  task automatic model_scan(input logic [15:0] pat);
    for (int k = 0; k < 16; k++) begin
      if (pat[k] == m_stable[k]) begin
        m_cnt[k] = 0;
      end else begin
        m_cnt[k]++;
        if (m_cnt[k] == DEB) begin
          m_cnt[k]    = 0;
          m_stable[k] = pat[k];
          if (!KEY_READY && exp_q.size() >= 4) m_ovf = 1'b1;
          else exp_q.push_back({KEY_READY, cur_scan, ~pat[k], 4'(k)});
        end
      end
    end
  endtask

  // Driver: called at a falling edge inside the first cycle of a scan.
  task automatic run_scan(input logic [15:0] pat, input logic rdy);
    KEY_READY = rdy;
    cur_scan  = cur_scan + 8'd1;
    model_scan(pat);
    keys_closed = pat;
    repeat (PERIOD) @(posedge CLK);
    @(negedge CLK);
    check("keys_down", 32'(KEYS_DOWN), 32'(m_stable));
    check("overflow", 32'(OVERFLOW), 32'(m_ovf));
    check("key_valid", 32'(KEY_VALID), 32'(exp_q.size() != 0));
  endtask

  // Monitor: pops the expected queue on every accepted event.
  logic       hold_vld;
  logic [4:0] hold_ev;
  logic [EW-1:0] e;
  always begin
    @(negedge CLK);
    #1;
    if (RST) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld && KEY_VALID) check("hold_head", 32'({KEY_RELEASE, KEY_CODE}), 32'(hold_ev));
      hold_vld = KEY_VALID && !KEY_READY;
      hold_ev  = {KEY_RELEASE, KEY_CODE};
      if (KEY_VALID && KEY_READY) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL event: got code=%0d release=%0d expected no event", KEY_CODE, KEY_RELEASE);
        end else begin
          e = exp_q.pop_front();
          check("event_code", 32'(KEY_CODE), 32'(e[3:0]));
          check("event_release", 32'(KEY_RELEASE), 32'(e[4]));
          if (e[13]) check("event_scan", 32'(cur_scan), 32'(e[12:5]));
        end
      end
    end
  end

  logic [15:0] rpat;
  int          hold;

  initial begin
    n_chk       = 0;
    n_err       = 0;
    cur_scan    = '0;
    keys_closed = '0;
    KEY_READY   = 1'b1;
    hold_vld    = 1'b0;
    model_reset();
    RST = 1'b1;
    #3;
    check("rst_ioout", 32'(IOOut), 0);
    check("rst_valid", 32'(KEY_VALID), 0);
    check("rst_code", 32'({KEY_RELEASE, KEY_CODE}), 0);
    check("rst_keys_down", 32'(KEYS_DOWN), 0);
    check("rst_overflow", 32'(OVERFLOW), 0);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    #1 check("first_drive", 32'(IOOut), 32'h1);

    // Press key 9 (column 2, row 1) for 5 scans
    repeat (5) run_scan(16'h0200, 1'b1);
    // Release of key 9, then a bounce that never settles
    repeat (3) run_scan(16'h0000, 1'b1);
    repeat (2) run_scan(16'h0200, 1'b1);
    repeat (2) run_scan(16'h0000, 1'b1);
    // Keys 3 and 12 together, then released together
    repeat (3) run_scan(16'h1008, 1'b1);
    repeat (3) run_scan(16'h0000, 1'b1);

    // Random key patterns held for random scan counts
    for (int i = 0; i < 16; i++) begin
      rpat = 16'($urandom) & 16'($urandom) & 16'($urandom);
      hold = $urandom_range(1, 4);
      for (int j = 0; j < hold; j++) run_scan(rpat, 1'b1);
    end
    repeat (3) run_scan(16'h0000, 1'b1);

    // Five presses in one scan with the consumer stalled: the fifth is dropped
    repeat (3) run_scan(16'h8452, 1'b0);
    check("ovf_set", 32'(OVERFLOW), 1);
    run_scan(16'h8452, 1'b1);
    repeat (3) run_scan(16'h0000, 1'b1);
    check("ovf_sticky", 32'(OVERFLOW), 1);

    // Two events queued, then reset during column 2 SAMPLE
    repeat (3) run_scan(16'h0021, 1'b0);
    check("two_queued", 32'(KEY_VALID), 1);
    KEY_READY = 1'b0;
    cur_scan  = cur_scan + 8'd1;
    repeat (2 * (SETTLE + 1) + SETTLE) @(posedge CLK);
    @(negedge CLK);
    check("col2_sample_drive", 32'(IOOut), 32'h4);
    #2 RST = 1'b1;
    model_reset();
    #1;
    check("midrst_ioout", 32'(IOOut), 0);
    check("midrst_valid", 32'(KEY_VALID), 0);
    check("midrst_code", 32'({KEY_RELEASE, KEY_CODE}), 0);
    check("midrst_keys_down", 32'(KEYS_DOWN), 0);
    check("midrst_overflow", 32'(OVERFLOW), 0);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    #1 check("post_rst_drive", 32'(IOOut), 32'h1);
    repeat (4) run_scan(16'h0021, 1'b1);
    repeat (3) run_scan(16'h0000, 1'b1);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/keypad_scan_controller.md
KEYPAD_SCAN_CONTROLLER -- requirements
Module: keypad_scan_controller

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: column-drive cycles before sampling (range 1..15).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 3: consecutive differing scans required to flip a key (range 1..7).
REQ-003 SHALL have port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port IOIn, input, 4: matrix row sense; bit r high = key in row r closed on the driven column.
REQ-006 SHALL have port IOOut, output, 4: one-hot column drive, or 0 when idle.
REQ-007 SHALL have port KEY_VALID, output, 1: event available at the head of the FIFO.
REQ-008 SHALL have port KEY_READY, input, 1: consumer accepts the head event.
REQ-009 SHALL have port KEY_CODE, output, 4: key index of the head event, equal to column*4 + row.
REQ-010 SHALL have port KEY_RELEASE, output, 1: head event type; 1 = release, 0 = press.
REQ-011 SHALL have port KEYS_DOWN, output, 16: debounced state; bit k = key k held.
REQ-012 SHALL have port OVERFLOW, output, 1: sticky flag; an event was dropped.

Function
REQ-013 FSM SHALL use states DRIVE, SAMPLE, EVAL and GAP, with column index c (0..3) and key index k (0..15).
REQ-014 DRIVE SHALL hold IOOut = 1<<c for SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-015 SAMPLE SHALL hold IOOut = 1<<c, capture raw[c*4+r] = IOIn[r] for r = 0..3, and take one cycle.
REQ-016 After SAMPLE, if c < 3 the FSM SHALL increment c and go to DRIVE; if c = 3 it SHALL set k = 0 and go to EVAL.
REQ-017 EVAL SHALL take 16 cycles, one per key in ascending k, with IOOut = 0.
REQ-018 In each EVAL cycle: if raw[k] equals stable[k], cnt[k] SHALL clear to 0; otherwise cnt[k] SHALL increment.
REQ-019 When cnt[k] reaches DEBOUNCE_SCANS, stable[k] SHALL toggle, cnt[k] SHALL clear, and a push {code=k, release=!new stable[k]} SHALL be issued in that same cycle.
REQ-020 GAP SHALL take one cycle with IOOut = 0, then go to DRIVE with c = 0.
REQ-021 Scan period SHALL be 4*(SETTLE_CYCLES+1)+17 cycles (37 at the default setting).
REQ-022 KEYS_DOWN SHALL equal stable[15:0] and SHALL update on the EVAL cycle of the affected key.
REQ-023 The event FIFO SHALL be 4 deep, first-in first-out.
REQ-024 KEY_VALID SHALL equal FIFO not empty.
REQ-025 A pop SHALL occur when KEY_VALID && KEY_READY.
REQ-026 A pushed event SHALL be visible on the outputs no earlier than the cycle after the push.
REQ-027 On simultaneous push and pop when full, both SHALL occur and the occupancy SHALL stay 4.
REQ-028 On simultaneous push and pop when empty, only the push SHALL take effect.
REQ-029 A push when full with no pop SHALL drop the event and set OVERFLOW.
REQ-030 KEY_CODE and KEY_RELEASE SHALL be stable while KEY_VALID && !KEY_READY.
REQ-031 Multiple key changes in one scan SHALL be pushed in ascending code order on consecutive EVAL cycles.

Reset
REQ-032 While RST = 1, IOOut, KEY_VALID, KEY_CODE, KEY_RELEASE, KEYS_DOWN and OVERFLOW SHALL be 0, immediately and without waiting for a clock edge.
REQ-033 Reset SHALL clear the FIFO, raw, stable, cnt and c.
REQ-034 After reset, the FSM SHALL enter DRIVE with c = 0 and a fresh SETTLE_CYCLES count.
REQ-035 Reset mid-scan SHALL discard the partial scan, with no event emitted.
REQ-036 OVERFLOW SHALL clear only by reset.

Structure
REQ-037 Package keypad_pkg SHALL hold the state enum, NUM_COLS=4, NUM_ROWS=4, NUM_KEYS=16 and the key-code width of 4.
REQ-038 The FIFO SHALL be a sub-module named key_event_fifo (5-bit entries, depth 4, with push/pop/full/empty).
REQ-039 The scan FSM and debounce logic SHALL reside in keypad_scan_controller.

Verification
REQ-040 Press: defaults, KEY_READY=1, IOIn[1] high while IOOut=4'b0100, for 5 scans -> exactly one event, code 9, release 0, pushed in the 3rd scan's EVAL; KEYS_DOWN[9]=1.
REQ-041 Bounce: same key closed for only 2 scans, then open -> no event; KEYS_DOWN stays 0.
REQ-042 Release: key 9 held, then open for 3 scans -> one event, code 9, release 1; KEYS_DOWN[9]=0.
REQ-043 Overflow: KEY_READY=0, 5 distinct presses -> 4 events held in order; OVERFLOW=1 after the 5th; draining yields the first 4 codes.
REQ-044 Simultaneous: keys 3 and 12 closed in the same scans -> events 3 then 12 on consecutive cycles with KEY_READY=1.
REQ-045 Reset: assert RST during column 2 SAMPLE with 2 events queued -> IOOut=0, KEY_VALID=0, KEYS_DOWN=0 at once; first DRIVE after release drives 4'b0001.
